// File: rtl/vme_a16_regfile.sv
// VME A16/D16 slave register file: strobe synchronisation, A16 window decode,
// DTACK/BERR handshake and NREG 16-bit registers, each RW or RO, with
// per-register access strobes towards the channel logic.
module vme_a16_regfile #(
   parameter logic [15:0]     BASE_ADDR = 16'h7C80,
   parameter int              NREG      = 16,
   parameter logic [NREG-1:0] RO_MASK   = {NREG{1'b0}},
   parameter int              DTACK_DLY = 0
) (
   input  logic                 I_CLK_32M,
   input  logic                 I_VME_SYSRESET,
   input  logic                 I_VME_AS,
   input  logic                 I_VME_DS0,
   input  logic                 I_VME_DS1,
   input  logic                 I_VME_WR,
   input  logic                 I_VME_LWORD,
   input  logic [15:1]          I_VME_A,
   input  logic [5:0]           I_VME_AM,
   input  logic [15:0]          I_VME_D,
   output logic [15:0]          O_VME_D,
   output logic                 O_VME_D_OE,
   output logic                 O_VME_DTACK_D,
   output logic                 O_VME_DTACK_EN,
   output logic                 O_VME_BERR,
   output logic [NREG*16-1:0]   O_REG_Q,
   input  logic [NREG*16-1:0]   I_REG_RD,
   output logic [NREG-1:0]      O_WR_STB,
   output logic [NREG-1:0]      O_RD_STB
);

   localparam int         IW      = $clog2(NREG);
   localparam logic [3:0] DLY_CNT = 4'(DTACK_DLY);

   typedef enum logic [2:0] {
      IDLE,
      SKEW,
      DECODE,
      ACK,
      BERR,
      RELEASE,
      WAIT_REL
   } state_t;

   state_t            state_q;

   logic [1:0]        asSync_q;
   logic [1:0]        ds0Sync_q;
   logic [1:0]        ds1Sync_q;
   logic              asS;
   logic              ds0S;
   logic              ds1S;
   logic              dsBothHigh;

   logic              winHit;
   logic              amOk;

   logic [IW-1:0]     idx_q;
   logic              hit_q;
   logic              amOk_q;
   logic              isWrite_q;
   logic              lword_q;
   logic [15:0]       data_q;
   logic              beHi_q;
   logic              beLo_q;
   logic [3:0]        cnt_q;

   logic [15:0]       regFile_q [NREG];
   logic [15:0]       roWord [NREG];
   logic [15:0]       wrWord_d;
   logic [15:0]       rdWord_d;

   logic [15:0]       vmeD_q;
   logic              oe_q;
   logic              dtackD_q;
   logic              dtackEn_q;
   logic              berr_q;
   logic [NREG-1:0]   wrStb_q;
   logic [NREG-1:0]   rdStb_q;

   // Two-flop synchronisers for the asynchronous strobes; left out of reset so
   // that strobes held low across a reset still read as low afterwards.
   always_ff @(posedge I_CLK_32M) begin
      asSync_q  <= {asSync_q[0],  I_VME_AS};
      ds0Sync_q <= {ds0Sync_q[0], I_VME_DS0};
      ds1Sync_q <= {ds1Sync_q[0], I_VME_DS1};
   end

   assign asS        = asSync_q[1];
   assign ds0S       = ds0Sync_q[1];
   assign ds1S       = ds1Sync_q[1];
   assign dsBothHigh = ds0S & ds1S;

   assign winHit = (I_VME_A[15:IW+1] == BASE_ADDR[15:IW+1]);
   assign amOk   = (I_VME_AM == 6'h29) || (I_VME_AM == 6'h2D);

   // Split the packed read-only input bus into one word per register.
   always_comb begin
      for (int i = 0; i < NREG; i++) begin
         roWord[i] = I_REG_RD[16*i +: 16];
      end
   end

   // Merge enabled byte lanes into the addressed word and pick the read source.
   always_comb begin
      wrWord_d = regFile_q[idx_q];
      if (beHi_q) begin
         wrWord_d[15:8] = data_q[15:8];
      end
      if (beLo_q) begin
         wrWord_d[7:0] = data_q[7:0];
      end
      rdWord_d = RO_MASK[idx_q] ? roWord[idx_q] : regFile_q[idx_q];
   end

   // Present register contents; read-only words track the user logic directly.
   always_comb begin
      O_REG_Q = '0;
      for (int i = 0; i < NREG; i++) begin
         O_REG_Q[16*i +: 16] = RO_MASK[i] ? roWord[i] : regFile_q[i];
      end
   end

   // Bus handshake state machine with registered bus outputs and strobes.
   always_ff @(posedge I_CLK_32M) begin
      if (I_VME_SYSRESET) begin
         state_q   <= WAIT_REL;
         idx_q     <= '0;
         hit_q     <= 1'b0;
         amOk_q    <= 1'b0;
         isWrite_q <= 1'b0;
         lword_q   <= 1'b1;
         data_q    <= '0;
         beHi_q    <= 1'b0;
         beLo_q    <= 1'b0;
         cnt_q     <= '0;
         vmeD_q    <= '0;
         oe_q      <= 1'b0;
         dtackD_q  <= 1'b1;
         dtackEn_q <= 1'b0;
         berr_q    <= 1'b0;
         wrStb_q   <= '0;
         rdStb_q   <= '0;
         for (int i = 0; i < NREG; i++) begin
            regFile_q[i] <= '0;
         end
      end else begin
         wrStb_q <= '0;
         rdStb_q <= '0;
         case (state_q)
            IDLE: begin
               if (!asS && (!ds0S || !ds1S)) begin
                  state_q <= SKEW;
               end
            end
            SKEW: begin
               idx_q     <= I_VME_A[IW:1];
               hit_q     <= winHit;
               amOk_q    <= amOk;
               isWrite_q <= ~I_VME_WR;
               lword_q   <= I_VME_LWORD;
               data_q    <= I_VME_D;
               beHi_q    <= ~ds1S;
               beLo_q    <= ~ds0S;
               state_q   <= DECODE;
            end
            DECODE: begin
               cnt_q <= '0;
               if (!hit_q || !amOk_q) begin
                  state_q <= WAIT_REL;
               end else if (!lword_q || (isWrite_q && RO_MASK[idx_q])) begin
                  berr_q  <= 1'b1;
                  state_q <= BERR;
               end else if (isWrite_q) begin
                  regFile_q[idx_q] <= wrWord_d;
                  wrStb_q[idx_q]   <= 1'b1;
                  state_q          <= ACK;
               end else begin
                  vmeD_q         <= rdWord_d;
                  rdStb_q[idx_q] <= 1'b1;
                  state_q        <= ACK;
               end
            end
            ACK: begin
               if (!dtackEn_q) begin
                  if (cnt_q == DLY_CNT) begin
                     dtackD_q  <= 1'b0;
                     dtackEn_q <= 1'b1;
                     oe_q      <= ~isWrite_q;
                  end else begin
                     cnt_q <= cnt_q + 4'd1;
                  end
               end else if (dsBothHigh) begin
                  dtackD_q <= 1'b1;
                  oe_q     <= 1'b0;
                  state_q  <= RELEASE;
               end
            end
            RELEASE: begin
               dtackEn_q <= 1'b0;
               state_q   <= IDLE;
            end
            BERR: begin
               if (dsBothHigh) begin
                  berr_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            WAIT_REL: begin
               if (dsBothHigh) begin
                  state_q <= IDLE;
               end
            end
            default: begin
               state_q <= WAIT_REL;
            end
         endcase
      end
   end

   assign O_VME_D        = vmeD_q;
   assign O_VME_D_OE     = oe_q;
   assign O_VME_DTACK_D  = dtackD_q;
   assign O_VME_DTACK_EN = dtackEn_q;
   assign O_VME_BERR     = berr_q;
   assign O_WR_STB       = wrStb_q;
   assign O_RD_STB       = rdStb_q;

endmodule

// File: doc/vme_a16_regfile.md
# vme_a16_regfile

Parametrised VME A16/D16 slave register file for the EA4163 board family. It sits between the VME bus buffers and the channel logic. It synchronises the asynchronous bus strobes, decodes the A16 window, and generates DTACK/BERR through a handshake state machine. It also provides NREG 16-bit registers, each either read-write or read-only, with per-register write and read strobes to the user logic.

## Interface
Parameters:
- BASE_ADDR, 16'h7C80, byte address of register 0; must be aligned to 2*NREG.
- NREG, 16, number of registers; power of two, 2..64.
- RO_MASK, {NREG{1'b0}}, bit i set means register i is read-only and is sourced from I_REG_RD.
- DTACK_DLY, 0, extra clock cycles inserted before DTACK is asserted; 0..15.

Ports:
- I_CLK_32M  in  1  system clock; the block's only clock.
- I_VME_SYSRESET  in  1  reset, synchronous, active-high.
- I_VME_AS, I_VME_DS0, I_VME_DS1  in  1 each  bus strobes, active-low, asynchronous to I_CLK_32M.
- I_VME_WR  in  1  VME WRITE*; low means write, high means read.
- I_VME_LWORD  in  1  must be high (D16 only).
- I_VME_A  in  [15:1]  address.
- I_VME_AM  in  [5:0]  address modifier.
- I_VME_D  in  16  data from the bus.
- O_VME_D  out  16  read data driven to the bus.
- O_VME_D_OE  out  1  enables the read data buffer.
- O_VME_DTACK_D, O_VME_DTACK_EN  out  1 each  DTACK level and DTACK driver enable; DTACK is asserted when D=0 and EN=1.
- O_VME_BERR  out  1  bus error, active-high to the buffer.
- O_REG_Q  out  NREG*16  register contents; register i occupies bits [16i+15:16i].
- I_REG_RD  in  NREG*16  read values for RO registers.
- O_WR_STB, O_RD_STB  out  NREG each  one-cycle access pulses.

## Operation
- AS, DS0 and DS1 each pass through a 2-flop synchroniser (as_s, ds0_s, ds1_s). Address, AM, WR and data are sampled directly; they are stable while the strobes are low.
- Register index = A[log2(NREG):1]. Window match = A[15:log2(NREG)+1] equal to the corresponding bits of BASE_ADDR.
- Accepted AM codes: 6'h29 and 6'h2D. Any other AM code is treated as not-ours.
- The state machine has states IDLE, SKEW, DECODE, ACK, BERR, RELEASE and WAIT_REL.
- IDLE: when as_s=0 and (ds0_s=0 or ds1_s=0), go to SKEW. SKEW is one cycle that absorbs DS0/DS1 skew.
- SKEW: capture index, AM, WR, LWORD, data and the byte enables (be_hi = !ds1_s, be_lo = !ds0_s), then go to DECODE.
- DECODE, in priority order:
  - Window miss or bad AM: go to WAIT_REL with no response.
  - LWORD=0, or a write to an RO register: go to BERR.
  - Write: update the enabled byte lanes of register i, pulse O_WR_STB[i], go to ACK.
  - Read: load O_VME_D from O_REG_Q (RW register) or I_REG_RD (RO register), pulse O_RD_STB[i], go to ACK.
- ACK: count DTACK_DLY cycles, then drive EN=1 and D=0, with O_VME_D_OE=1 on reads. Hold until ds0_s=1 and ds1_s=1, then go to RELEASE.
- RELEASE: one cycle with D=1, EN=1 and OE=0 (active negation), then go to IDLE with EN=0.
- BERR: O_VME_BERR=1 until both DS are high, then go to IDLE.
- WAIT_REL: stay until both DS are high, then go to IDLE.
- RO bits of O_REG_Q mirror I_REG_RD continuously.

## Timing
- Reset values: O_REG_Q RW bits 0, O_VME_D 0, O_VME_D_OE 0, O_VME_DTACK_D 1, O_VME_DTACK_EN 0, O_VME_BERR 0, all strobes 0. The state machine resets into WAIT_REL, so a cycle that is in flight during reset is never acknowledged.
- Cycle numbering: cycle 0 is the first edge on which the synchronised strobes are seen low in IDLE. SKEW is cycle 1 and DECODE is cycle 2.
- Register update and strobe pulse occur at the end of cycle 2.
- DTACK asserts at cycle 3+DTACK_DLY.
- DTACK deasserts 2 cycles after the DS rise reaches the synchroniser input, plus one RELEASE cycle before EN drops.
- A DS re-falling during RELEASE is ignored until IDLE.
- DS1 low alone writes D[15:8]; DS0 low alone writes D[7:0]. Reads always return the full word.
- A reset asserted in any state takes effect on the next edge: DTACK, BERR and OE drop at once, and the register writes of that cycle are discarded.

## Test plan
- Reset, then a read of 0x7C80 with AM=29: O_VME_D=0x0000, DTACK at cycle 3, O_RD_STB[0] pulses once.
- Write 0xA5C3 to 0x7C86 with both DS, then read it back: O_REG_Q[63:48]=0xA5C3, O_WR_STB[3] pulses once, read returns 0xA5C3.
- Write 0x1234 to 0x7C86 with DS1 only: register 3 reads 0x12C3.
- RO_MASK bit 5 set, I_REG_RD word 5 = 0xBEEF: read of 0x7C8A returns 0xBEEF; write to 0x7C8A gives BERR=1, register unchanged, no DTACK.
- Access to 0x7D00, or to 0x7C80 with AM=39: no DTACK, no BERR, no strobe; the next valid cycle is acknowledged normally.
- DTACK_DLY=4: DTACK at cycle 7. I_VME_SYSRESET pulsed in ACK while DS is held low: DTACK releases next edge and no new acknowledge is given until DS rises.
